// File: rtl/sink_d.sv
// D-channel sink: buffers memory responses in a 2-entry FIFO and steers the head
// to the refill (AccessAckData) or write-ack (AccessAck) port; illegal opcodes are dropped.
module sink_d #(
    parameter int OP_BITS     = 3,
    parameter int SIZE_BITS   = 3,
    parameter int SOURCE_BITS = 6,
    parameter int DATA_BITS   = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   sinkD_d_valid_i,
    output logic                   sinkD_d_ready_o,
    input  logic [OP_BITS-1:0]     sinkD_d_opcode_i,
    input  logic [SIZE_BITS-1:0]   sinkD_d_size_i,
    input  logic [SOURCE_BITS-1:0] sinkD_d_source_i,
    input  logic [DATA_BITS-1:0]   sinkD_d_data_i,

    output logic                   sinkD_resp_valid_o,
    input  logic                   sinkD_resp_ready_i,
    output logic [SOURCE_BITS-1:0] sinkD_resp_source_o,
    output logic [SIZE_BITS-1:0]   sinkD_resp_size_o,
    output logic [DATA_BITS-1:0]   sinkD_resp_data_o,

    output logic                   sinkD_putack_valid_o,
    input  logic                   sinkD_putack_ready_i,
    output logic [SOURCE_BITS-1:0] sinkD_putack_source_o,

    output logic                   sinkD_err_o,
    output logic [7:0]             sinkD_err_cnt_o
);

    localparam logic [OP_BITS-1:0] OP_ACK      = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_ACK_DATA = OP_BITS'(1);

    logic [OP_BITS-1:0]     op_mem     [2];
    logic [SIZE_BITS-1:0]   size_mem   [2];
    logic [SOURCE_BITS-1:0] source_mem [2];
    logic [DATA_BITS-1:0]   data_mem   [2];

    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       ready_en;
    logic       err;
    logic [7:0] err_cnt;

    logic [OP_BITS-1:0] head_op;
    logic               not_empty;
    logic               head_data;
    logic               head_ack;
    logic               head_illegal;
    logic               push;
    logic               pop;

    // ready_en keeps d_ready low through reset and raises it on the first edge after release
    assign sinkD_d_ready_o = ready_en && (count != 2'd2);

    assign head_op      = op_mem[rd_ptr];
    assign not_empty    = (count != 2'd0);
    assign head_data    = not_empty && (head_op == OP_ACK_DATA);
    assign head_ack     = not_empty && (head_op == OP_ACK);
    assign head_illegal = not_empty && !head_data && !head_ack;

    assign push = sinkD_d_valid_i && sinkD_d_ready_o;
    assign pop  = (head_data && sinkD_resp_ready_i)
               || (head_ack && sinkD_putack_ready_i)
               || head_illegal;

    assign sinkD_resp_valid_o    = head_data;
    assign sinkD_resp_source_o   = source_mem[rd_ptr];
    assign sinkD_resp_size_o     = size_mem[rd_ptr];
    assign sinkD_resp_data_o     = data_mem[rd_ptr];
    assign sinkD_putack_valid_o  = head_ack;
    assign sinkD_putack_source_o = source_mem[rd_ptr];
    assign sinkD_err_o           = err;
    assign sinkD_err_cnt_o       = err_cnt;

    // Payload storage needs no reset: the cleared count marks every slot as empty
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]     <= sinkD_d_opcode_i;
            size_mem[wr_ptr]   <= sinkD_d_size_i;
            source_mem[wr_ptr] <= sinkD_d_source_i;
            data_mem[wr_ptr]   <= sinkD_d_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            ready_en <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (head_illegal) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sink_d.sv
// Directed self-checking bench for sink_d: steering, backpressure, ordering,
// illegal-opcode drop/saturation and asynchronous reset.
module tb_sink_d;

    logic         clk;
    logic         rst_n;
    logic         dValid;
    logic         dReady;
    logic [2:0]   dOpcode;
    logic [2:0]   dSize;
    logic [5:0]   dSource;
    logic [255:0] dData;
    logic         respValid;
    logic         respReady;
    logic [5:0]   respSource;
    logic [2:0]   respSize;
    logic [255:0] respData;
    logic         putackValid;
    logic         putackReady;
    logic [5:0]   putackSource;
    logic         errFlag;
    logic [7:0]   errCnt;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [255:0] dataA;
    logic [255:0] dataB;
    logic [255:0] dataC;
    logic [255:0] dataD;

    sink_d dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sinkD_d_valid_i       (dValid),
        .sinkD_d_ready_o       (dReady),
        .sinkD_d_opcode_i      (dOpcode),
        .sinkD_d_size_i        (dSize),
        .sinkD_d_source_i      (dSource),
        .sinkD_d_data_i        (dData),
        .sinkD_resp_valid_o    (respValid),
        .sinkD_resp_ready_i    (respReady),
        .sinkD_resp_source_o   (respSource),
        .sinkD_resp_size_o     (respSize),
        .sinkD_resp_data_o     (respData),
        .sinkD_putack_valid_o  (putackValid),
        .sinkD_putack_ready_i  (putackReady),
        .sinkD_putack_source_o (putackSource),
        .sinkD_err_o           (errFlag),
        .sinkD_err_cnt_o       (errCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [5:0] src, input logic [255:0] data);
        dValid  = valid;
        dOpcode = op;
        dSize   = 3'd5;
        dSource = src;
        dData   = data;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dataA = {32{8'hA5}};
        dataB = {16{16'h1234}};
        dataC = {8{32'hDEADBEEF}};
        dataD = {64{4'h7}};
        rst_n = 1'b0;
        respReady = 1'b0;
        putackReady = 1'b0;
        applyStimulus(1'b0, 3'd0, 6'd0, '0);

        repeat (3) tick();
        checkOutput("rst_dready", dReady, 0);
        checkOutput("rst_respv", respValid, 0);
        checkOutput("rst_putv", putackValid, 0);
        checkOutput("rst_err", errFlag, 0);
        checkOutput("rst_errcnt", errCnt, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rel_dready", dReady, 1);

        // single AccessAckData, source 5
        respReady = 1'b1;
        putackReady = 1'b1;
        applyStimulus(1'b1, 3'd1, 6'd5, dataA);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        checkOutput("ad_respv", respValid, 1);
        checkOutput("ad_src", respSource, 5);
        checkOutput("ad_size", respSize, 5);
        checkOutput("ad_data", respData, dataA);
        checkOutput("ad_putv", putackValid, 0);
        tick();
        checkOutput("ad_respv_drop", respValid, 0);

        // AccessAck held under putack backpressure for 4 cycles
        putackReady = 1'b0;
        applyStimulus(1'b1, 3'd0, 6'd3, dataB);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ack_putv", putackValid, 1);
            checkOutput("ack_src", putackSource, 3);
            checkOutput("ack_respv", respValid, 0);
            if (i < 3) tick();
        end
        putackReady = 1'b1;
        tick();
        checkOutput("ack_popped", putackValid, 0);
        checkOutput("ack_respv_end", respValid, 0);

        // three back-to-back pushes against a stalled resp port
        respReady = 1'b0;
        applyStimulus(1'b1, 3'd1, 6'd10, dataA);
        tick();
        applyStimulus(1'b1, 3'd1, 6'd11, dataB);
        tick();
        checkOutput("full_dready", dReady, 0);
        applyStimulus(1'b1, 3'd1, 6'd12, dataC);
        tick();
        checkOutput("full_dready_hold", dReady, 0);
        checkOutput("ord_src0", respSource, 10);
        checkOutput("ord_data0", respData, dataA);
        respReady = 1'b1;
        tick();
        checkOutput("after_pop_dready", dReady, 1);
        checkOutput("ord_src1", respSource, 11);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        checkOutput("ord_src2", respSource, 12);
        checkOutput("ord_data2", respData, dataC);
        checkOutput("ord_respv2", respValid, 1);
        tick();
        checkOutput("ord_empty", respValid, 0);

        // illegal opcode 4 then a normal AccessAckData
        applyStimulus(1'b1, 3'd4, 6'd7, dataB);
        tick();
        applyStimulus(1'b1, 3'd1, 6'd8, dataD);
        checkOutput("ill_respv", respValid, 0);
        checkOutput("ill_putv", putackValid, 0);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        checkOutput("ill_err", errFlag, 1);
        checkOutput("ill_errcnt", errCnt, 1);
        checkOutput("ill_next_respv", respValid, 1);
        checkOutput("ill_next_src", respSource, 8);
        checkOutput("ill_next_data", respData, dataD);
        tick();
        checkOutput("ill_next_pop", respValid, 0);

        // 300 more illegal responses saturate the counter
        applyStimulus(1'b1, 3'd6, 6'd1, dataC);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 100) begin
                checkOutput("sat_mid_cnt", errCnt, 100);
                checkOutput("sat_mid_dready", dReady, 1);
            end
        end
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        tick();
        checkOutput("sat_cnt", errCnt, 255);
        checkOutput("sat_err", errFlag, 1);
        checkOutput("sat_respv", respValid, 0);

        // reset with two entries buffered
        putackReady = 1'b0;
        respReady = 1'b0;
        applyStimulus(1'b1, 3'd0, 6'd20, dataA);
        tick();
        applyStimulus(1'b1, 3'd0, 6'd21, dataB);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        checkOutput("pre_rst_putv", putackValid, 1);
        checkOutput("pre_rst_dready", dReady, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_putv", putackValid, 0);
        checkOutput("async_respv", respValid, 0);
        checkOutput("async_dready", dReady, 0);
        checkOutput("async_err", errFlag, 0);
        checkOutput("async_errcnt", errCnt, 0);
        tick();
        checkOutput("in_rst_dready", dReady, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_dready", dReady, 1);
        checkOutput("post_rst_putv", putackValid, 0);
        putackReady = 1'b1;
        tick();
        checkOutput("discarded_putv", putackValid, 0);
        applyStimulus(1'b1, 3'd0, 6'd33, dataC);
        tick();
        applyStimulus(1'b0, 3'd0, 6'd0, '0);
        checkOutput("post_rst_ack_v", putackValid, 1);
        checkOutput("post_rst_ack_src", putackSource, 33);
        tick();
        checkOutput("post_rst_ack_pop", putackValid, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/sink_d.md
SINK_D -- requirements
Module: sink_d

Interface
REQ-001 SHALL have parameter OP_BITS, default 3: width of the D-channel opcode.
REQ-002 SHALL have parameter SIZE_BITS, default 3: width of the D-channel size.
REQ-003 SHALL have parameter SOURCE_BITS, default 6: width of the request source ID.
REQ-004 SHALL have parameter DATA_BITS, default 256: width of the D-channel data beat.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port sinkD_d_valid_i, input, 1: a D response from main memory is valid.
REQ-008 SHALL have port sinkD_d_ready_o, output, 1: the block accepts the D response.
REQ-009 SHALL have port sinkD_d_opcode_i, input, OP_BITS: 0 = AccessAck, 1 = AccessAckData.
REQ-010 SHALL have ports sinkD_d_size_i, sinkD_d_source_i and sinkD_d_data_i, all inputs, of widths SIZE_BITS, SOURCE_BITS and DATA_BITS: the D payload.
REQ-011 SHALL have ports sinkD_resp_valid_o (output, 1) and sinkD_resp_ready_i (input, 1): the refill handshake.
REQ-012 SHALL have ports sinkD_resp_source_o (output, SOURCE_BITS), sinkD_resp_size_o (output, SIZE_BITS) and sinkD_resp_data_o (output, DATA_BITS): the refill payload.
REQ-013 SHALL have ports sinkD_putack_valid_o (output, 1) and sinkD_putack_ready_i (input, 1): the write-ack handshake.
REQ-014 SHALL have port sinkD_putack_source_o, output, SOURCE_BITS: the acked write source.
REQ-015 SHALL have port sinkD_err_o, output, 1: sticky flag set on an illegal opcode.
REQ-016 SHALL have port sinkD_err_cnt_o, output, 8: count of dropped illegal responses.

Function
REQ-017 SHALL buffer D responses in a 2-entry FIFO holding opcode, size, source and data, with a 1-bit wrapping read pointer, a 1-bit wrapping write pointer and a 2-bit count.
REQ-018 SHALL drive sinkD_d_ready_o = (count != 2), derived from registered state only, with no combinational path from any input.
REQ-019 SHALL push on d_valid_i && d_ready_o; a push into an empty FIFO SHALL appear on an output in the next cycle (1-cycle latency, no bypass).
REQ-020 SHALL present head opcode 1 only on the resp port and head opcode 0 only on the putack port; the other valid SHALL be 0.
REQ-021 SHALL pop the head on (resp_valid_o && resp_ready_i) || (putack_valid_o && putack_ready_i).
REQ-022 SHALL, when the head opcode is neither 0 nor 1, assert no output valid, pop the head in that cycle, set err_o, and increment err_cnt_o, saturating at 255.
REQ-023 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-024 SHALL NOT accept a push when full, even if a pop occurs in the same cycle.
REQ-025 SHALL hold output payload stable while a valid is asserted and ready is low.
REQ-026 SHALL drive the outputs directly from the FIFO head with registered muxing only, and SHALL contain no combinational ready-to-valid path.
REQ-027 SHALL, when idle (count = 0), hold resp_valid_o = putack_valid_o = 0 and leave the payload outputs don't-care.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-transfer, immediately clear the pointers, count, err_o and err_cnt_o.
REQ-029 SHALL, during reset, drive all valid outputs to 0 and d_ready_o to 0, and SHALL discard buffered entries.
REQ-030 SHALL drive d_ready_o = 1 from the first clock edge after rst_n deasserts.

Verification
REQ-031 SHALL cover: single AccessAckData (source 5, data 0xA5..) with resp_ready_i = 1 -> resp_valid_o high for exactly 1 cycle, one cycle after acceptance, with source 5 and identical data.
REQ-032 SHALL cover: AccessAck (source 3) with putack_ready_i = 0 for 4 cycles -> putack_valid_o and source 3 held stable for 4 cycles, then popped, with resp_valid_o = 0 throughout.
REQ-033 SHALL cover: 3 back-to-back pushes with resp_ready_i = 0 -> d_ready_o = 0 after 2 accepted; the third is accepted only in the cycle after the first pop; output order is preserved.
REQ-034 SHALL cover: opcode 4 injected, then opcode 1 -> err_o = 1, err_cnt_o = 1, and the following AccessAckData is delivered normally.
REQ-035 SHALL cover: 300 illegal opcodes -> err_cnt_o saturates at 255.
REQ-036 SHALL cover: rst_n asserted with 2 entries buffered -> valids drop to 0 asynchronously; after release, count = 0 and d_ready_o = 1 at the first edge.
